evg_event_injector: RTL and testbench

- Transmit-side counterpart of the event logger: the processor supplies event codes, and this block merges them into the EVG transmit stream.
- Runs entirely in the evgTxClk domain and sits between the EVG sequencer output and the transceiver TX port.
- Queued entries are {delay, code}. Each code is emitted in the first free (null-event) low-byte slot once its delay has expired, which gives a simple timed event sequence.
- The upper byte (distributed bus / data buffer) passes through untouched.

---
 rtl/evg_event_injector.sv | 142 ++++++++++++++
 tb/tb_evg_event_injector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/evg_event_injector.sv
// rtl/evg_event_injector.sv - merges queued {delay, code} events into free low-byte slots of the EVG TX stream
module evg_event_injector #(
    parameter int FIFO_AW = 4,
    parameter     DEBUG   = "false"
) (
    input  logic               evgTxClk,
    input  logic               evgReset,
    input  logic               wrValid,
    input  logic [7:0]         wrCode,
    input  logic [15:0]        wrDelay,
    output logic               wrReady,
    input  logic [15:0]        upTxData,
    input  logic [1:0]         upTxCharIsK,
    output logic [15:0]        evgTxData,
    output logic [1:0]         evgTxCharIsK,
    output logic               busy,
    output logic [FIFO_AW:0]   fifoCount,
    output logic [15:0]        injectCount,
    output logic [15:0]        dropCount
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    (* mark_debug = DEBUG *) state_t        state_q;
    state_t                                 state_d;
    (* mark_debug = DEBUG *) logic [7:0]    head_code_q;
    logic [7:0]                             head_code_d;
    (* mark_debug = DEBUG *) logic [15:0]   cnt_q;
    logic [15:0]                            cnt_d;
    (* mark_debug = DEBUG *) logic [FIFO_AW:0] count_q;
    logic [FIFO_AW:0]                       count_d;
    logic [FIFO_AW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [15:0]                            inj_cnt_q, inj_cnt_d;
    logic [15:0]                            drop_q, drop_d;
    logic [15:0]                            tx_data_q, tx_data_d;
    logic [1:0]                             tx_k_q, tx_k_d;

    logic [23:0] mem_q [DEPTH];
    logic [23:0] head_entry;
    logic        push;
    logic        pop;
    logic        eligible;
    logic        inject;

    assign wrReady    = (count_q != FULL_COUNT);
    assign push       = wrValid && wrReady;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign eligible   = !upTxCharIsK[0] && (upTxData[7:0] == 8'h00);

    // Queue storage is not reset; flushing the pointers and count is enough.
    always_ff @(posedge evgTxClk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wrDelay, wrCode};
        end
    end

    always_comb begin
        state_d     = state_q;
        head_code_d = head_code_q;
        cnt_d       = cnt_q;
        inject      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    head_code_d = head_entry[7:0];
                    cnt_d       = head_entry[23:8];
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (head_code_q == 8'h00) begin
                    // Null code is a pure delay entry: nothing to emit.
                    state_d = IDLE;
                end else if (eligible) begin
                    inject  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        inj_cnt_d = inject ? inj_cnt_q + 16'd1 : inj_cnt_q;
        drop_d    = (wrValid && !wrReady && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        tx_data_d = {upTxData[15:8], inject ? head_code_q : upTxData[7:0]};
        tx_k_d    = {upTxCharIsK[1], inject ? 1'b0 : upTxCharIsK[0]};
    end

    always_ff @(posedge evgTxClk) begin
        if (evgReset) begin
            state_q     <= IDLE;
            head_code_q <= 8'h00;
            cnt_q       <= 16'd0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inj_cnt_q   <= 16'd0;
            drop_q      <= 16'd0;
            tx_data_q   <= 16'd0;
            tx_k_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            head_code_q <= head_code_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inj_cnt_q   <= inj_cnt_d;
            drop_q      <= drop_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
        end
    end

    assign evgTxData    = tx_data_q;
    assign evgTxCharIsK = tx_k_q;
    assign busy         = (state_q == WAIT);
    assign fifoCount    = count_q;
    assign injectCount  = inj_cnt_q;
    assign dropCount    = drop_q;

endmodule

// File: tb/tb_evg_event_injector.sv
// tb/tb_evg_event_injector.sv - scoreboard bench for evg_event_injector
module tb_evg_event_injector;

    logic        evgTxClk = 1'b0;
    logic        evgReset;
    logic        wrValid;
    logic [7:0]  wrCode;
    logic [15:0] wrDelay;
    logic        wrReady;
    logic [15:0] upTxData;
    logic [1:0]  upTxCharIsK;
    logic [15:0] evgTxData;
    logic [1:0]  evgTxCharIsK;
    logic        busy;
    logic [4:0]  fifoCount;
    logic [15:0] injectCount;
    logic [15:0] dropCount;

    evg_event_injector #(.FIFO_AW(4), .DEBUG("false")) dut (
        .evgTxClk     (evgTxClk),
        .evgReset     (evgReset),
        .wrValid      (wrValid),
        .wrCode       (wrCode),
        .wrDelay      (wrDelay),
        .wrReady      (wrReady),
        .upTxData     (upTxData),
        .upTxCharIsK  (upTxCharIsK),
        .evgTxData    (evgTxData),
        .evgTxCharIsK (evgTxCharIsK),
        .busy         (busy),
        .fifoCount    (fifoCount),
        .injectCount  (injectCount),
        .dropCount    (dropCount)
    );

    always #5 evgTxClk = ~evgTxClk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_inj_cyc = -1;
    int         prev_inj_cyc = 0;
    bit         have_prev = 0;
    bit         spacing_en = 0;
    logic [7:0] exp_q[$];
    int         exp_inj = 0;
    int         t0;
    int         te;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge evgTxClk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Any low-byte/K0 difference from the previous upstream word is an injection.
    always @(posedge evgTxClk) begin
        logic [15:0] up_p;
        logic [1:0]  k_p;
        logic        rst_p;
        logic [7:0]  e;
        up_p  = upTxData;
        k_p   = upTxCharIsK;
        rst_p = evgReset;
        cyc   = cyc + 1;
        #1;
        if (!rst_p) begin
            check("passthru_hi", {23'd0, evgTxCharIsK[1], evgTxData[15:8]}, {23'd0, k_p[1], up_p[15:8]});
            if ({evgTxCharIsK[0], evgTxData[7:0]} != {k_p[0], up_p[7:0]}) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inj", {23'd0, evgTxCharIsK[0], evgTxData[7:0]}, {23'd0, k_p[0], up_p[7:0]});
                end else begin
                    e = exp_q.pop_front();
                    check("inj_code", {24'd0, evgTxData[7:0]}, {24'd0, e});
                    check("inj_slot", {23'd0, k_p[0], up_p[7:0]}, 32'd0);
                end
                if (spacing_en && have_prev) check("inj_spacing", cyc - prev_inj_cyc, 2);
                prev_inj_cyc = cyc;
                have_prev    = 1;
                last_inj_cyc = cyc;
            end
        end
    end

    task automatic write(input logic [7:0] code, input logic [15:0] dly, input bit expect_emit);
        wrValid = 1'b1;
        wrCode  = code;
        wrDelay = dly;
        if (expect_emit) begin
            exp_q.push_back(code);
            exp_inj++;
        end
    endtask

    initial begin
        evgReset    = 1'b1;
        wrValid     = 1'b0;
        wrCode      = 8'h00;
        wrDelay     = 16'd0;
        upTxData    = 16'h1234;
        upTxCharIsK = 2'b11;
        #1;
        steps(2);
        check("rst_data", evgTxData, 16'h0000);
        check("rst_k", evgTxCharIsK, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifoCount, 5'd0);
        check("rst_ready", wrReady, 1'b1);
        check("rst_inj", injectCount, 16'd0);
        check("rst_drop", dropCount, 16'd0);
        evgReset    = 1'b0;
        upTxData    = 16'h0000;
        upTxCharIsK = 2'b00;
        steps(2);

        // Delay 0 on idle stream: code at edge 2.
        write(8'h2A, 16'd0, 1);
        step(); t0 = cyc;
        wrValid = 1'b0;
        step();
        check("a_busy_e1", busy, 1'b1);
        step();
        check("a_data_e2", evgTxData, 16'h002A);
        check("a_busy_e2", busy, 1'b0);
        step();
        check("a_data_e3", evgTxData, 16'h0000);
        steps(2);
        check("a_latency", last_inj_cyc - t0, 2);
        check("a_injcnt", injectCount, exp_inj);

        // Busy upstream holds injection off; comma characters are never overwritten.
        upTxData = 16'h0050;
        write(8'h11, 16'd0, 1);
        step();
        wrValid = 1'b0;
        steps(5);
        upTxData    = 16'h00BC;
        upTxCharIsK = 2'b01;
        steps(3);
        check("b_still_busy", busy, 1'b1);
        upTxData    = 16'h0000;
        upTxCharIsK = 2'b00;
        step(); te = cyc;
        check("b_data", evgTxData, 16'h0011);
        steps(3);
        check("b_latency", last_inj_cyc, te);

        // Delay 5: code at edge 7.
        write(8'h33, 16'd5, 1);
        step(); t0 = cyc;
        wrValid = 1'b0;
        steps(10);
        check("c_latency_d5", last_inj_cyc - t0, 7);

        // Null-code delay entry followed by a real code.
        write(8'h00, 16'd3, 0);
        step(); t0 = cyc;
        write(8'h44, 16'd0, 1);
        step();
        wrValid = 1'b0;
        steps(10);
        check("c_latency_null", last_inj_cyc - t0, 7);
        check("c_injcnt", injectCount, exp_inj);

        // Upper byte and K1 pass through during an injection.
        upTxData    = 16'hA500;
        upTxCharIsK = 2'b10;
        write(8'h5C, 16'd0, 1);
        step();
        wrValid = 1'b0;
        step();
        step();
        check("e_data", evgTxData, 16'hA55C);
        check("e_k", evgTxCharIsK, 2'b10);
        upTxData    = 16'h0000;
        upTxCharIsK = 2'b00;
        steps(3);

        // Fill: 17 accepted (head + 16 queued), 18th dropped.
        upTxData = 16'h0050;
        for (int i = 0; i < 18; i++) begin
            write(8'h60 + 8'(i), 16'd0, i < 17);
            step();
            if (i == 16) begin
                check("d_ready_full", wrReady, 1'b0);
                check("d_count_full", fifoCount, 5'd16);
                check("d_busy", busy, 1'b1);
            end
        end
        wrValid = 1'b0;
        check("d_drop", dropCount, 16'd1);
        check("d_count_after", fifoCount, 5'd16);
        spacing_en = 1;
        have_prev  = 0;
        upTxData   = 16'h0000;
        steps(40);
        spacing_en = 0;
        check("d_drained", exp_q.size(), 0);
        check("d_injcnt", injectCount, exp_inj);
        check("d_count_empty", fifoCount, 5'd0);

        // Reset while WAITing with 5 queued discards everything.
        upTxData = 16'h0050;
        for (int i = 0; i < 6; i++) begin
            write(8'h90 + 8'(i), 16'd0, 0);
            step();
        end
        wrValid = 1'b0;
        check("r_busy_pre", busy, 1'b1);
        check("r_count_pre", fifoCount, 5'd5);
        evgReset = 1'b1;
        step();
        check("r_count", fifoCount, 5'd0);
        check("r_busy", busy, 1'b0);
        check("r_inj", injectCount, 16'd0);
        check("r_drop", dropCount, 16'd0);
        check("r_data", evgTxData, 16'h0000);
        check("r_k", evgTxCharIsK, 2'b00);
        check("r_ready", wrReady, 1'b1);
        evgReset = 1'b0;
        upTxData = 16'h0000;
        steps(40);
        check("r_no_emit", injectCount, 16'd0);
        check("r_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
